// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master = byte source / memory side, slave = the loader.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// 32-bit words, writes them to IMEM and holds the CPU until the load is done.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LEN_W       = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_words,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      part_q;

    logic last_word;
    logic too_long;

    // word_idx + 1 never exceeds DEPTH_WORDS, which LEN_W is sized to hold
    assign last_word = (word_idx + LEN_W'(1)) == len_q;
    assign too_long  = 32'(len_words) > 32'(DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            len_q          <= '0;
            word_idx       <= '0;
            byte_cnt       <= 2'd0;
            part_q         <= 24'd0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= 32'd0;
            bus.imem_wdata <= 32'd0;
            cpu_hold       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        if (len_words == '0) begin
                            state          <= DONE;
                            bus.byte_ready <= 1'b0;
                            cpu_hold       <= 1'b0;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            err            <= 1'b0;
                        end else if (too_long) begin
                            state          <= ERR;
                            bus.byte_ready <= 1'b0;
                            cpu_hold       <= 1'b1;
                            busy           <= 1'b0;
                            done           <= 1'b0;
                            err            <= 1'b1;
                        end else begin
                            state          <= LOAD;
                            len_q          <= len_words;
                            word_idx       <= '0;
                            byte_cnt       <= 2'd0;
                            bus.byte_ready <= 1'b1;
                            cpu_hold       <= 1'b1;
                            busy           <= 1'b1;
                            done           <= 1'b0;
                            err            <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    // start is deliberately ignored while a load is running
                    if (bus.byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        unique case (byte_cnt)
                            2'd0: part_q[7:0]   <= bus.byte_data;
                            2'd1: part_q[15:8]  <= bus.byte_data;
                            2'd2: part_q[23:16] <= bus.byte_data;
                            2'd3: begin
                                bus.imem_we    <= 1'b1;
                                bus.imem_wdata <= {bus.byte_data, part_q};
                                bus.imem_addr  <= 32'({word_idx, 2'b00});
                                word_idx       <= word_idx + LEN_W'(1);
                                if (last_word) begin
                                    state          <= DONE;
                                    bus.byte_ready <= 1'b0;
                                    cpu_hold       <= 1'b0;
                                    busy           <= 1'b0;
                                    done           <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-queue reference
// model; every cycle the outputs are compared with the model's prediction.
module tb_imem_loader;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LW    = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len_words;
    logic          cpu_hold, busy, done, err;

    imem_loader_if bus ();

    imem_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: loading / done / error flags plus the bytes of the open word
    bit           m_loading, m_done, m_err, m_we;
    int           m_target, m_words;
    byte unsigned m_bytes[$];
    logic [31:0]  m_addr, m_data;

    int          n_we_obs;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // predict the effect of the coming edge, take it, then compare every output
    task automatic tick();
        m_we = 1'b0;
        if (!rst_n) begin
            m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_bytes.delete();
            m_addr = 32'd0; m_data = 32'd0;
        end else if (start && !m_loading) begin
            m_done = 1'b0; m_err = 1'b0;
            if (len_words == 0)              m_done = 1'b1;
            else if (int'(len_words) > DEPTH) m_err = 1'b1;
            else begin
                m_loading = 1'b1;
                m_target  = int'(len_words);
                m_words   = 0;
                m_bytes.delete();
            end
        end else if (m_loading && bus.byte_valid) begin
            m_bytes.push_back(bus.byte_data);
            if (m_bytes.size() == 4) begin
                m_we   = 1'b1;
                m_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_addr = 32'(m_words * 4);
                m_words++;
                m_bytes.delete();
                if (m_words == m_target) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (bus.imem_we === 1'b1) begin
            n_we_obs++;
            obs_addr.push_back(bus.imem_addr);
            obs_data.push_back(bus.imem_wdata);
        end
        check("byte_ready", 32'(bus.byte_ready), 32'(m_loading));
        check("busy",       32'(busy),           32'(m_loading));
        check("done",       32'(done),           32'(m_done));
        check("err",        32'(err),            32'(m_err));
        check("cpu_hold",   32'(cpu_hold),       32'(!m_done));
        check("imem_we",    32'(bus.imem_we),    32'(m_we));
        check("imem_addr",  bus.imem_addr,       m_addr);
        check("imem_wdata", bus.imem_wdata,      m_data);
    endtask

    task automatic clear_obs();
        n_we_obs = 0;
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic feed(input logic [7:0] b, input logic v);
        bus.byte_valid = v;
        bus.byte_data  = b;
        tick();
    endtask

    task automatic pulse_start(input int len);
        start          = 1'b1;
        len_words      = LW'(len);
        bus.byte_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // random load with byte_valid asserted pct% of cycles, bounded by a cycle budget
    task automatic run_load(input int len, input int pct);
        int budget;
        budget = len * 4 * 20 + 50;
        pulse_start(len);
        for (int c = 0; c < budget && m_loading; c++)
            feed(8'($urandom), logic'($urandom_range(99) < pct));
        check("load_finished", 32'(busy), 32'd0);
        bus.byte_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] prog[8];
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        rst_n = 1'b0; start = 1'b0; len_words = '0;
        bus.byte_valid = 1'b0; bus.byte_data = 8'd0;
        m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
        m_target = 0; m_words = 0; m_addr = 32'd0; m_data = 32'd0;
        clear_obs();

        // reset, with a start pulse that reset must override
        tick();
        start = 1'b1; len_words = LW'(1);
        tick();
        start = 1'b0; rst_n = 1'b1;
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_addr", bus.imem_addr, 32'd0);
        tick();

        // two-word program
        clear_obs();
        pulse_start(2);
        for (int i = 0; i < 8; i++) feed(prog[i], 1'b1);
        bus.byte_valid = 1'b0;
        tick();
        check("prog_writes", 32'(n_we_obs), 32'd2);
        check("prog_w0_addr", obs_addr[0], 32'h0);
        check("prog_w0_data", obs_data[0], 32'h0000_0013);
        check("prog_w1_addr", obs_addr[1], 32'h4);
        check("prog_w1_data", obs_data[1], 32'h0010_8093);
        check("prog_done", 32'(done), 32'd1);
        check("prog_hold", 32'(cpu_hold), 32'd0);
        check("prog_ready", 32'(bus.byte_ready), 32'd0);

        // three words with byte_valid toggling
        clear_obs();
        pulse_start(3);
        for (int i = 0; i < 60 && m_loading; i++) feed(8'($urandom), logic'(i % 2 == 0));
        bus.byte_valid = 1'b0;
        tick();
        check("tog_writes", 32'(n_we_obs), 32'd3);
        for (int i = 0; i < 3 && i < n_we_obs; i++) check("tog_addr", obs_addr[i], 32'(i * 4));

        // zero-length load
        clear_obs();
        pulse_start(0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        tick();
        check("zero_writes", 32'(n_we_obs), 32'd0);

        // oversize load then a one-word recovery
        pulse_start(257);
        check("big_err", 32'(err), 32'd1);
        check("big_hold", 32'(cpu_hold), 32'd1);
        check("big_ready", 32'(bus.byte_ready), 32'd0);
        clear_obs();
        pulse_start(1);
        feed(8'hAA, 1'b1); feed(8'hBB, 1'b1); feed(8'hCC, 1'b1); feed(8'hDD, 1'b1);
        bus.byte_valid = 1'b0;
        tick();
        check("rec_writes", 32'(n_we_obs), 32'd1);
        if (n_we_obs > 0) begin
            check("rec_addr", obs_addr[0], 32'h0);
            check("rec_data", obs_data[0], 32'hDDCC_BBAA);
        end

        // reset in the middle of the second word
        clear_obs();
        pulse_start(2);
        for (int i = 0; i < 6; i++) feed(8'($urandom), 1'b1);
        rst_n = 1'b0;
        feed(8'h55, 1'b1);
        rst_n = 1'b1;
        feed(8'h66, 1'b1);
        feed(8'h77, 1'b0);
        check("rst_mid_writes", 32'(n_we_obs), 32'd1);
        check("rst_mid_hold", 32'(cpu_hold), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        clear_obs();
        run_load(1, 100);
        check("rst_fresh_addr", (n_we_obs > 0) ? obs_addr[0] : 32'hFFFF_FFFF, 32'h0);

        // start during LOAD is ignored
        clear_obs();
        pulse_start(2);
        for (int i = 0; i < 3; i++) feed(8'($urandom), 1'b1);
        start = 1'b1; len_words = LW'(5);
        feed(8'($urandom), 1'b1);
        start = 1'b0;
        for (int i = 0; i < 40 && m_loading; i++) feed(8'($urandom), 1'b1);
        bus.byte_valid = 1'b0;
        tick();
        check("ign_writes", 32'(n_we_obs), 32'd2);
        check("ign_done", 32'(done), 32'd1);

        // random loads, ending with a full-depth load
        for (int t = 0; t < 12; t++) begin
            int len;
            clear_obs();
            len = int'($urandom_range(12, 1));
            run_load(len, int'($urandom_range(100, 25)));
            check("rnd_writes", 32'(n_we_obs), 32'(len));
        end
        clear_obs();
        run_load(int'(DEPTH), 100);
        check("full_writes", 32'(n_we_obs), 32'(DEPTH));
        check("full_last_addr", (n_we_obs > 0) ? obs_addr[n_we_obs-1] : 32'd0, 32'((DEPTH - 1) * 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, is the instruction memory capacity in 32-bit words.
REQ-002 Parameter LEN_W, default 9, is the width of the word-count field and SHALL hold the value DEPTH_WORDS.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 start  input  1  single-cycle request to begin a load; len_words is sampled in the same cycle.
REQ-006 len_words  input  LEN_W  number of 32-bit words to load.
REQ-007 byte_valid  input  1  upstream byte present on byte_data.
REQ-008 byte_data  input  8  program byte stream, little-endian within each word.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle; a byte transfers when byte_valid and byte_ready are both 1.
REQ-010 imem_we  output  1  one-cycle instruction memory write strobe.
REQ-011 imem_addr  output  32  byte address of the write, equal to word index times 4.
REQ-012 imem_wdata  output  32  assembled instruction word.
REQ-013 cpu_hold  output  1  high keeps the processor PC and register writes frozen.
REQ-014 busy  output  1  high in LOAD state.
REQ-015 done  output  1  high in DONE state.
REQ-016 err  output  1  high in ERR state.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, DONE and ERR; all outputs SHALL be registered.
REQ-018 From IDLE, DONE or ERR, start with len_words=0 SHALL go to DONE with no write.
REQ-019 From IDLE, DONE or ERR, start with len_words > DEPTH_WORDS SHALL go to ERR with no write.
REQ-020 From IDLE, DONE or ERR, any other start SHALL go to LOAD, latch len_words, and clear the word index and byte counter.
REQ-021 start SHALL be ignored in LOAD.
REQ-022 byte_ready SHALL be 1 in every LOAD cycle and 0 in every other state; there is no backpressure inside LOAD.
REQ-023 The byte counter SHALL count 0..3 and wrap.
REQ-024 Accepted byte k of a word (k=0..3) SHALL occupy bits [8k+7:8k].
REQ-025 On acceptance of byte 3, in the next cycle imem_we SHALL be 1 for exactly one cycle.
REQ-026 In that write cycle, imem_wdata SHALL be the assembled word and imem_addr SHALL be the word index times 4.
REQ-027 The word index SHALL increment after each write.
REQ-028 A byte accepted in the same cycle as imem_we SHALL begin the next word and SHALL NOT be lost.
REQ-029 When the write of word index len_words-1 issues, the FSM SHALL go to DONE in the same cycle the strobe is asserted.
REQ-030 After the final write, byte_ready SHALL be 0 from the next cycle onward.
REQ-031 Maximum throughput SHALL be one byte per cycle, which is one word per 4 cycles.
REQ-032 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.
REQ-033 cpu_hold SHALL be 1 in IDLE, LOAD and ERR, and 0 only in DONE.
REQ-034 cpu_hold SHALL rise in the same cycle that DONE is left for LOAD.
REQ-035 The byte counter SHALL reach 0 exactly at the final write, so no partial word remains at DONE.

Reset
REQ-036 When rst_n=0 at a clock edge, the state SHALL become IDLE.
REQ-037 Reset values SHALL be: cpu_hold=1; byte_ready=0; imem_we=0; busy=0; done=0; err=0; imem_addr=0; imem_wdata=0; byte counter=0; word index=0.
REQ-038 Reset asserted mid-LOAD SHALL discard any partial word and issue no write in the reset cycle or after it.
REQ-039 Reset SHALL take priority over start.

Verification
REQ-040 Reset, then start with len_words=2, then bytes 13,00,00,00,93,80,10,00 one per cycle.
- Two writes: addr 0x0 data 0x00000013, then addr 0x4 data 0x00108093.
- done=1, cpu_hold=0 and byte_ready=0 after the second write.
REQ-041 start with len_words=3 and byte_valid toggling every other cycle.
- Exactly 3 writes at addr 0x0, 0x4, 0x8.
- Each imem_we is 1 cycle wide and follows byte 3 of its word by one cycle.
REQ-042 start with len_words=0 -> DONE next cycle, no imem_we, cpu_hold=0.
REQ-043 start with len_words=257 (DEPTH_WORDS=256) -> err=1, cpu_hold=1, byte_ready=0.
- A following start with len_words=1 and bytes AA,BB,CC,DD -> write addr 0x0 data 0xDDCCBBAA.
REQ-044 Reset after 6 accepted bytes of a 2-word load -> exactly one write total (word 0).
- After reset: IDLE, cpu_hold=1; a fresh load restarts at addr 0x0.
REQ-045 start pulsed during LOAD with len_words=5 -> ignored; the load completes with the original count.
